cache_fill_fsm: RTL and testbench

Miss-handling controller for the MEM stage: on a data- or instruction-cache miss it fetches one 16-byte block (8 × 16-bit words) from a pipelined, fixed-latency main memory and streams it into the cache data array. It then writes the tag array and releases the pipeline stall. It sits between the cache lookup logic (upstream: miss detection) and the main-memory model (downstream). Its data-array writes and stall output are the signals the CPU testbench observes as memory-stage activity.

---
 rtl/cache_fill_fsm_pkg.sv | 18 +
 rtl/cache_fill_fsm_fill_counter.sv | 35 +++
 rtl/cache_fill_fsm.sv | 135 +++++++++++++
 tb/tb_cache_fill_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm_pkg : block geometry and fill-controller state encoding
// Revision 1.0
// ============================================================================
package cache_fill_fsm_pkg;

  localparam int c_BLOCK_BYTES     = 16;
  localparam int c_WORDS_PER_BLOCK = 8;
  localparam int c_OFFSET_BITS     = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_fill_fsm_fill_counter.sv
`default_nettype none
// ============================================================================
// fill_counter : saturating word counter with sync clear, enable, done flag
// Revision 1.0
// ============================================================================
module fill_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Holds at LIMIT so a stray enable can never wrap into a new block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_done) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// cache_fill_fsm : fetches one cache block from pipelined memory on a miss
// Revision 1.0
// ============================================================================
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = c_WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_miss_detected,
  input  logic [ADDR_W-1:0]                  i_miss_address,
  input  logic                               i_memory_valid,
  input  logic [DATA_W-1:0]                  i_memory_data,
  output logic                               o_fsm_busy,
  output logic                               o_mem_enable,
  output logic [ADDR_W-1:0]                  o_memory_address,
  output logic                               o_write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] o_data_array_word,
  output logic [DATA_W-1:0]                  o_data_array_data,
  output logic                               o_write_tag_array
);

  localparam int c_CNT_W   = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int c_WORD_W  = $clog2(WORDS_PER_BLOCK);
  localparam int c_BYTE_SH = $clog2(DATA_W / 8);
  localparam int c_OFF_W   = c_WORD_W + c_BYTE_SH;
  localparam logic [ADDR_W-1:0]  c_BLK_MASK  = ~ADDR_W'((1 << c_OFF_W) - 1);
  localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(WORDS_PER_BLOCK - 1);

  fill_state_e         r_state;
  fill_state_e         w_state_nxt;
  logic [ADDR_W-1:0]   r_base;

  logic                w_in_fill;
  logic                w_cnt_clear;
  logic                w_issue_en;
  logic                w_recv_en;
  logic [c_CNT_W-1:0]  w_issue_cnt;
  logic [c_CNT_W-1:0]  w_recv_cnt;
  logic                w_issue_done;
  logic                w_recv_done;
  logic [ADDR_W-1:0]   w_issue_off;

  assign w_in_fill   = (r_state == ST_FILL);
  assign w_cnt_clear = (r_state == ST_IDLE);
  assign w_issue_en  = w_in_fill && !w_issue_done;
  assign w_recv_en   = w_in_fill && i_memory_valid && !w_recv_done;
  assign w_issue_off = ADDR_W'(w_issue_cnt) << c_BYTE_SH;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Base is captured only when a fill is accepted; later address changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (!w_in_fill && i_miss_detected) begin
      r_base <= i_miss_address & c_BLK_MASK;
    end
  end

  fill_counter #(
    .WIDTH (c_CNT_W),
    .LIMIT (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_issue_en),
    .o_count  (w_issue_cnt),
    .o_done   (w_issue_done)
  );

  fill_counter #(
    .WIDTH (c_CNT_W),
    .LIMIT (WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_cnt_clear),
    .i_enable (w_recv_en),
    .o_count  (w_recv_cnt),
    .o_done   (w_recv_done)
  );

  assign o_fsm_busy = w_in_fill;

  // Issue side runs off counters only; receive side is combinational from i_memory_valid.
  always_comb begin
    w_state_nxt        = r_state;
    o_mem_enable       = 1'b0;
    o_memory_address   = '0;
    o_write_data_array = 1'b0;
    o_data_array_word  = '0;
    o_data_array_data  = '0;
    o_write_tag_array  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_miss_detected) begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        if (!w_issue_done) begin
          o_mem_enable     = 1'b1;
          o_memory_address = r_base + w_issue_off;
        end
        if (i_memory_valid) begin
          o_write_data_array = 1'b1;
          o_data_array_word  = w_recv_cnt[c_WORD_W-1:0];
          o_data_array_data  = i_memory_data;
          if (w_recv_cnt == c_LAST_WORD) begin
            o_write_tag_array = 1'b1;
            w_state_nxt       = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// tb_cache_fill_fsm : randomized bench with pipelined memory and timing model
// Revision 1.0
// ============================================================================
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss  = 1'b0;
  logic [15:0] maddr = '0;
  logic        mvalid = 1'b0;
  logic [15:0] mdata  = '0;

  logic        o_fsm_busy, o_mem_enable, o_write_data_array, o_write_tag_array;
  logic [15:0] o_memory_address, o_data_array_data;
  logic [2:0]  o_data_array_word;

  cache_fill_fsm #(
    .WORDS_PER_BLOCK (8),
    .ADDR_W          (16),
    .DATA_W          (16)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_miss_detected    (miss),
    .i_miss_address     (maddr),
    .i_memory_valid     (mvalid),
    .i_memory_data      (mdata),
    .o_fsm_busy         (o_fsm_busy),
    .o_mem_enable       (o_mem_enable),
    .o_memory_address   (o_memory_address),
    .o_write_data_array (o_write_data_array),
    .o_data_array_word  (o_data_array_word),
    .o_data_array_data  (o_data_array_data),
    .o_write_tag_array  (o_write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ret;
    logic [15:0] d;
  } rsp_t;
  rsp_t q[$];

  int          cyc = 0, n_chk = 0, n_err = 0;
  bit          chk_en = 1'b0, spur_en = 1'b0;
  int          mem_L = 4;
  logic [15:0] salt_cur = '0;

  // Fill timeline model: a fill accepted at the end of cycle S-1 is busy S..S+L+7.
  bit          m_in = 1'b0;
  int          m_S = 0, m_L = 0;
  logic [15:0] m_base = '0, m_salt = '0;

  int          lg_busy, lg_en, lg_wr, lg_first, lg_tag;
  logic [15:0] lg_first_addr, lg_last_addr;
  logic [15:0] lg_wd[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_cycle();
    int k;
    bit e_en, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    logic [2:0]  e_word;
    k      = cyc - m_S;
    e_en   = m_in && (k < c_WORDS_PER_BLOCK);
    e_wr   = m_in && (k >= m_L) && (k < m_L + c_WORDS_PER_BLOCK);
    e_tag  = m_in && (k == m_L + c_WORDS_PER_BLOCK - 1);
    e_addr = e_en ? m_base + 16'(2 * k) : '0;
    e_word = e_wr ? 3'(k - m_L) : '0;
    e_data = e_wr ? m_salt + 16'(k - m_L) : '0;
    check("fsm_busy", 32'(o_fsm_busy), 32'(m_in));
    check("mem_enable", 32'(o_mem_enable), 32'(e_en));
    check("write_data_array", 32'(o_write_data_array), 32'(e_wr));
    check("write_tag_array", 32'(o_write_tag_array), 32'(e_tag));
    if (!m_in || e_en) check("memory_address", 32'(o_memory_address), 32'(e_addr));
    if (!m_in || e_wr) begin
      check("data_array_word", 32'(o_data_array_word), 32'(e_word));
      check("data_array_data", 32'(o_data_array_data), 32'(e_data));
    end
  endtask

  task automatic log_reset();
    lg_busy = 0; lg_en = 0; lg_wr = 0; lg_first = -1; lg_tag = -1;
    lg_first_addr = '0; lg_last_addr = '0;
    for (int i = 0; i < 8; i++) lg_wd[i] = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    if (o_mem_enable === 1'b1)
      q.push_back(rsp_t'{ret: cyc + mem_L,
                         d: salt_cur + {13'b0, o_memory_address[c_OFFSET_BITS-1:1]}});
    if (o_fsm_busy === 1'b1) begin
      if (lg_busy == 0) lg_first = cyc;
      lg_busy++;
    end
    if (o_mem_enable === 1'b1) begin
      if (lg_en == 0) lg_first_addr = o_memory_address;
      lg_last_addr = o_memory_address;
      lg_en++;
    end
    if (o_write_data_array === 1'b1) begin
      if (lg_wr < 8) lg_wd[lg_wr] = o_data_array_data;
      lg_wr++;
    end
    if (o_write_tag_array === 1'b1) lg_tag = cyc;
    @(posedge clk);
    if (!rst_n) begin
      m_in = 1'b0;
    end else if (m_in) begin
      if (cyc - m_S == m_L + c_WORDS_PER_BLOCK - 1) m_in = 1'b0;
    end else if (miss) begin
      m_in   = 1'b1;
      m_S    = cyc + 1;
      m_L    = mem_L;
      m_salt = salt_cur;
      m_base = maddr & ~16'(c_BLOCK_BYTES - 1);
    end
    cyc++;
    #1;
    if (q.size() > 0 && q[0].ret == cyc) begin
      mvalid = 1'b1;
      mdata  = q[0].d;
      void'(q.pop_front());
    end else if (spur_en && q.size() == 0 && !m_in) begin
      mvalid = 1'($urandom_range(0, 1));
      mdata  = 16'($urandom);
    end else begin
      mvalid = 1'b0;
      mdata  = 16'($urandom);
    end
  endtask

  task automatic run_fill(input logic [15:0] a, input int lat, input logic [15:0] s,
                          input bit mutate, input bit b2b, input logic [15:0] nxt,
                          input int abort_k);
    bit seen;
    int n, k;
    seen = 1'b0;
    n = 0;
    mem_L = lat;
    salt_cur = s;
    log_reset();
    miss = 1'b1;
    maddr = a;
    while (1) begin
      tick();
      n++;
      if (m_in) seen = 1'b1;
      if (seen && !m_in) break;
      if (n > 200) begin
        n_chk++;
        n_err++;
        $display("FAIL fill_timeout @cycle %0d: got %0d cycles, expected completion", cyc, n);
        break;
      end
      if (m_in) begin
        k = cyc - m_S;
        if (mutate) maddr = 16'($urandom);
        if (abort_k >= 0 && k == abort_k) rst_n = 1'b0;
        if (b2b && k == m_L + c_WORDS_PER_BLOCK - 1) maddr = nxt;
      end
    end
    rst_n = 1'b1;
    if (!b2b) miss = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic fill_literals(input string nm, input int busy, input logic [15:0] fa,
                               input logic [15:0] la, input logic [15:0] w0, input logic [15:0] w7);
    check({nm, "_busy_cycles"}, 32'(lg_busy), 32'(busy));
    check({nm, "_issue_count"}, 32'(lg_en), 32'd8);
    check({nm, "_write_count"}, 32'(lg_wr), 32'd8);
    check({nm, "_first_addr"}, 32'(lg_first_addr), 32'(fa));
    check({nm, "_last_addr"}, 32'(lg_last_addr), 32'(la));
    check({nm, "_first_data"}, 32'(lg_wd[0]), 32'(w0));
    check({nm, "_last_data"}, 32'(lg_wd[7]), 32'(w7));
    check({nm, "_tag_offset"}, 32'(lg_tag - lg_first), 32'(busy - 1));
  endtask

  initial begin
    int          lat, abort_k;
    bit          mut, b2b;
    logic [15:0] a, nxt;

    rst_n = 1'b0;
    log_reset();
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_busy", 32'(o_fsm_busy), 32'd0);
    check("reset_mem_enable", 32'(o_mem_enable), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_fill(16'h1234, 4, 16'hA000, 1'b0, 1'b0, '0, -1);
    fill_literals("basic", 12, 16'h1230, 16'h123E, 16'hA000, 16'hA007);

    run_fill(16'hFFFF, 4, 16'h5000, 1'b0, 1'b0, '0, -1);
    fill_literals("top_of_mem", 12, 16'hFFF0, 16'hFFFE, 16'h5000, 16'h5007);

    run_fill(16'h0100, 1, 16'h1100, 1'b0, 1'b0, '0, -1);
    fill_literals("lat1", 9, 16'h0100, 16'h010E, 16'h1100, 16'h1107);

    run_fill(16'h3456, 10, 16'h2200, 1'b0, 1'b0, '0, -1);
    fill_literals("lat10", 18, 16'h3450, 16'h345E, 16'h2200, 16'h2207);

    spur_en = 1'b1;
    log_reset();
    repeat (10) tick();
    check("spurious_idle_writes", 32'(lg_wr), 32'd0);
    run_fill(16'h4444, 3, 16'h3300, 1'b1, 1'b0, '0, -1);
    fill_literals("addr_toggle", 11, 16'h4440, 16'h444E, 16'h3300, 16'h3307);
    spur_en = 1'b0;

    run_fill(16'h5550, 4, 16'h6600, 1'b0, 1'b0, '0, 5);
    check("post_reset_busy", 32'(o_fsm_busy), 32'd0);
    check("post_reset_mem_enable", 32'(o_mem_enable), 32'd0);
    log_reset();
    drain();
    check("late_return_writes", 32'(lg_wr), 32'd0);
    run_fill(16'h0040, 4, 16'h7700, 1'b0, 1'b0, '0, -1);
    fill_literals("after_reset", 12, 16'h0040, 16'h004E, 16'h7700, 16'h7707);

    run_fill(16'h7000, 4, 16'h8800, 1'b0, 1'b1, 16'h2000, -1);
    check("b2b_gap_busy", 32'(o_fsm_busy), 32'd0);
    run_fill(16'h2000, 4, 16'h9900, 1'b0, 1'b0, '0, -1);
    fill_literals("b2b_second", 12, 16'h2000, 16'h200E, 16'h9900, 16'h9907);

    for (int it = 0; it < 40; it++) begin
      lat     = int'($urandom_range(1, 10));
      a       = 16'($urandom);
      nxt     = 16'($urandom);
      mut     = 1'($urandom_range(0, 1));
      abort_k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat + 7)) : -1;
      b2b     = (abort_k < 0) && ($urandom_range(0, 3) == 0);
      spur_en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) tick();
      run_fill(a, lat, 16'($urandom), mut, b2b, nxt, abort_k);
      if (b2b) run_fill(nxt, int'($urandom_range(1, 10)), 16'($urandom), mut, 1'b0, '0, -1);
      if (abort_k >= 0) drain();
    end
    spur_en = 1'b0;
    drain();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
